// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 10;

  // Odd parity: data bits plus the parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] par_and_data);
    return ^par_and_data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines, debounces the clock and flags its
// filtered falling edges.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall_tick,
  output logic data_sync
);

  logic                  c_meta_reg;
  logic                  c_sync_reg;
  logic                  d_meta_reg;
  logic                  d_sync_reg;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  fclk_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_meta_reg <= 1'b1;
      c_sync_reg <= 1'b1;
      d_meta_reg <= 1'b1;
      d_sync_reg <= 1'b1;
      filt_reg   <= '1;
      fclk_reg   <= 1'b1;
    end else begin
      c_meta_reg <= ps2c;
      c_sync_reg <= c_meta_reg;
      d_meta_reg <= ps2d;
      d_sync_reg <= d_meta_reg;
      filt_reg   <= {filt_reg[FILTER_LEN-2:0], c_sync_reg};
      if (&filt_reg) begin
        fclk_reg <= 1'b1;
      end else if (~|filt_reg) begin
        fclk_reg <= 1'b0;
      end
    end
  end

  // High in exactly the cycle before the filtered clock drops to 0.
  assign fall_tick = fclk_reg & ~|filt_reg;
  assign data_sync = d_sync_reg;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and folds F0/E0 prefixes
// into flags on the next scan code. Parity checking: PS2_PARITY_CHECK_EN.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic fall_tick;
  logic data_sync;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .fall_tick (fall_tick),
    .data_sync (data_sync)
  );

  state_t                    state_reg, state_next;
  logic [PS2_FRAME_BITS-1:0] shift_reg, shift_next;
  logic [3:0]                bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0]             timer_reg, timer_next;
  logic                      brk_pend_reg, brk_pend_next;
  logic                      ext_pend_reg, ext_pend_next;
  logic [7:0]                scan_code_reg, scan_code_next;
  logic                      break_flag_reg, break_flag_next;
  logic                      ext_flag_reg, ext_flag_next;
  logic                      code_valid_reg, code_valid_next;
  logic                      frame_err_reg, frame_err_next;

  logic stop_ok;
  logic parity_ok;
  logic [7:0] rx_byte;

  // shift_reg holds {stop, parity, d7..d0} once the frame is complete.
  assign rx_byte   = shift_reg[7:0];
  assign stop_ok   = shift_reg[9];
  assign parity_ok = !PARITY_EN || odd_parity_ok(shift_reg[8:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      timer_reg      <= '0;
      brk_pend_reg   <= 1'b0;
      ext_pend_reg   <= 1'b0;
      scan_code_reg  <= 8'h00;
      break_flag_reg <= 1'b0;
      ext_flag_reg   <= 1'b0;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      timer_reg      <= timer_next;
      brk_pend_reg   <= brk_pend_next;
      ext_pend_reg   <= ext_pend_next;
      scan_code_reg  <= scan_code_next;
      break_flag_reg <= break_flag_next;
      ext_flag_reg   <= ext_flag_next;
      code_valid_reg <= code_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    timer_next      = timer_reg;
    brk_pend_next   = brk_pend_reg;
    ext_pend_next   = ext_pend_reg;
    scan_code_next  = scan_code_reg;
    break_flag_next = break_flag_reg;
    ext_flag_next   = ext_flag_reg;
    code_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fall_tick && !data_sync) begin
          state_next   = ST_RECV;
          bit_cnt_next = '0;
          timer_next   = '0;
        end
      end
      ST_RECV: begin
        if (fall_tick) begin
          shift_next   = {data_sync, shift_reg[PS2_FRAME_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          timer_next   = '0;
          if (bit_cnt_reg == 4'(PS2_FRAME_BITS - 1)) begin
            state_next = ST_CHECK;
          end
        end else if (timer_reg >= TW'(TIMEOUT_CYC)) begin
          // Stalled frame: drop it along with any half-built prefix sequence.
          state_next    = ST_IDLE;
          brk_pend_next = 1'b0;
          ext_pend_next = 1'b0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_CHECK: begin
        state_next = ST_IDLE;
        if (!stop_ok || !parity_ok) begin
          frame_err_next = 1'b1;
          brk_pend_next  = 1'b0;
          ext_pend_next  = 1'b0;
        end else if (rx_byte == PS2_BREAK) begin
          brk_pend_next = 1'b1;
        end else if (rx_byte == PS2_EXT) begin
          ext_pend_next = 1'b1;
        end else begin
          scan_code_next  = rx_byte;
          break_flag_next = brk_pend_reg;
          ext_flag_next   = ext_pend_reg;
          code_valid_next = 1'b1;
          brk_pend_next   = 1'b0;
          ext_pend_next   = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign scan_code  = scan_code_reg;
  assign code_valid = code_valid_reg;
  assign break_flag = break_flag_reg;
  assign ext_flag   = ext_flag_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: drives PS/2 frames and checks outputs every cycle
// against a key-event model of the protocol.
module tb_ps2_scan_rx;

  localparam int FL   = 8;
  localparam int TOUT = 1000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, break_flag, ext_flag, frame_err;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .break_flag (break_flag),
    .ext_flag   (ext_flag),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
  } event_t;

  event_t     exp_q[$];
  bit         brk_p = 0, ext_p = 0;
  logic [7:0] h_scan = 8'h00;
  bit         h_brk = 0, h_ext = 0;
  int         rst_cyc = -1;
  int         n_valid = 0, n_err = 0;
  int         total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Protocol-level model: what the keyboard event stream must turn into.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop, input int fall_cyc);
    event_t ev;
    bit pok;
    pok = ((^{b, par}) == 1'b1) || !PAR_EN;
    ev.at = fall_cyc + FL + 4;
    ev.err = 0; ev.code = b; ev.brk = brk_p; ev.ext = ext_p;
    if (!stop || !pok) begin
      ev.err = 1;
      exp_q.push_back(ev);
      brk_p = 0; ext_p = 0;
    end else if (b == 8'hF0) begin
      brk_p = 1;
    end else if (b == 8'hE0) begin
      ext_p = 1;
    end else begin
      exp_q.push_back(ev);
      brk_p = 0; ext_p = 0;
    end
  endtask

  initial begin
    event_t ev;
    bit exp_v, exp_e;
    forever begin
      @(negedge clk);
      if (cyc == rst_cyc) begin
        h_scan = 8'h00; h_brk = 0; h_ext = 0;
      end
      exp_v = 0; exp_e = 0;
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        ev = exp_q.pop_front();
        if (ev.err) exp_e = 1;
        else begin
          exp_v = 1; h_scan = ev.code; h_brk = ev.brk; h_ext = ev.ext;
        end
      end
      chk("code_valid", {31'd0, code_valid}, {31'd0, exp_v});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_e});
      chk("scan_code", {24'd0, scan_code}, {24'd0, h_scan});
      chk("break_flag", {31'd0, break_flag}, {31'd0, h_brk});
      chk("ext_flag", {31'd0, ext_flag}, {31'd0, h_ext});
      if (code_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    $display("frame byte=%02h par=%0d stop=%0d bits=%0d glitch=%0d", b, par, stop, nbits, glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      repeat (25) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) model_frame(b, par, stop, cyc);
      repeat (50) @(negedge clk);
      ps2c = 1'b1;
      if (i == glitch_bit) begin
        repeat (15) @(negedge clk);
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (7) @(negedge clk);
      end else begin
        repeat (25) @(negedge clk);
      end
    end
    ps2d = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 11, -1);
  endtask

  initial begin
    int v0, e0;
    repeat (3) @(negedge clk);
    chk("rst_scan_code", {24'd0, scan_code}, 32'h0);
    chk("rst_code_valid", {31'd0, code_valid}, 32'h0);
    chk("rst_break_flag", {31'd0, break_flag}, 32'h0);
    chk("rst_ext_flag", {31'd0, ext_flag}, 32'h0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Make code
    v0 = n_valid;
    good(8'h0C);
    chk("make_count", n_valid - v0, 1);
    chk("make_scan", {24'd0, scan_code}, 32'h0C);
    chk("make_brk", {31'd0, break_flag}, 32'h0);

    // Break sequence
    v0 = n_valid;
    good(8'hF0);
    chk("brk_f0_nostrobe", n_valid - v0, 0);
    good(8'h0C);
    chk("brk_count", n_valid - v0, 1);
    chk("brk_scan", {24'd0, scan_code}, 32'h0C);
    chk("brk_flag", {31'd0, break_flag}, 32'h1);

    // Bad parity on 04
    v0 = n_valid; e0 = n_err;
    good(8'hF0);
    send_frame(8'h04, 1'b1, 1'b1, 11, -1);
    if (PAR_EN) begin
      chk("par_err_count", n_err - e0, 1);
      chk("par_valid_count", n_valid - v0, 0);
    end else begin
      chk("nopar_scan", {24'd0, scan_code}, 32'h04);
      chk("nopar_brk", {31'd0, break_flag}, 32'h1);
    end
    good(8'h1C);
    chk("after_par_scan", {24'd0, scan_code}, 32'h1C);
    chk("after_par_brk", {31'd0, break_flag}, 32'h0);

    // Extended release
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    chk("ext_scan", {24'd0, scan_code}, 32'h75);
    chk("ext_brk", {31'd0, break_flag}, 32'h1);
    chk("ext_ext", {31'd0, ext_flag}, 32'h1);

    // Short glitch inside a frame must not add a bit
    v0 = n_valid;
    send_frame(8'h0C, 1'b1, 1'b1, 11, 3);
    chk("glitch_count", n_valid - v0, 1);
    chk("glitch_scan", {24'd0, scan_code}, 32'h0C);

    // Stalled frame times out and drops the pending break
    v0 = n_valid; e0 = n_err;
    good(8'hF0);
    send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
    repeat (TOUT + 300) @(negedge clk);
    brk_p = 0; ext_p = 0;
    chk("tout_nostrobe", (n_valid - v0) + (n_err - e0), 0);
    good(8'h1C);
    chk("tout_scan", {24'd0, scan_code}, 32'h1C);
    chk("tout_brk", {31'd0, break_flag}, 32'h0);

    // Reset in the middle of a frame
    good(8'hF0);
    send_frame(8'h33, 1'b1, 1'b1, 5, -1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    rst_cyc = cyc + 1;
    brk_p = 0; ext_p = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_scan", {24'd0, scan_code}, 32'h0);
    chk("mrst_valid", {31'd0, code_valid}, 32'h0);
    repeat (20) @(negedge clk);
    good(8'h0C);
    chk("mrst_after_scan", {24'd0, scan_code}, 32'h0C);
    chk("mrst_after_brk", {31'd0, break_flag}, 32'h0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
